// File: rtl/sdram_burst_interface.sv
// Burst front end for the SDRAM controller: expands one start/address/length command into
// consecutive Avalon word transfers, with pipelined reads and valid/ready data streams.
module sdram_burst_interface #(
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 16,
    parameter int BE_W      = DATA_W / 8,
    parameter int MAX_BURST = 8,
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_write,
    input  logic              start_read,
    input  logic [ADDR_W-1:0] address,
    input  logic [LEN_W-1:0]  length,
    input  logic [BE_W-1:0]   byteenable,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [BE_W-1:0]   sdram_byteenable_n,
    output logic              sdram_chipselect,
    output logic [DATA_W-1:0] sdram_writedata,
    output logic              sdram_read_n,
    output logic              sdram_write_n,
    input  logic [DATA_W-1:0] sdram_readdata,
    input  logic              sdram_readdatavalid,
    input  logic              sdram_waitrequest
);

    typedef enum logic [2:0] {StIdle, StWrCmd, StRdCmd, StRdDrain, StDone} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [LEN_W-1:0]    returned_q, returned_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                error_q, error_d;
    logic                len_ok;
    logic                rd_beat;
    logic                rd_last;

    assign len_ok  = (length != '0) && (length <= MAX_LEN);
    // Returned data only counts while a read burst is live.
    assign rd_beat = sdram_readdatavalid && (state_q == StRdCmd || state_q == StRdDrain);
    assign rd_last = rd_beat && (returned_q + LEN_W'(1) == len_q);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        be_d       = be_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        error_d    = 1'b0;
        if (rd_beat) begin
            returned_d = returned_q + LEN_W'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (start_write || start_read) begin
                    if (len_ok) begin
                        addr_d     = address;
                        len_d      = length;
                        be_d       = byteenable;
                        issued_d   = '0;
                        returned_d = '0;
                        state_d    = start_write ? StWrCmd : StRdCmd;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StWrCmd: begin
                if (wr_valid && !sdram_waitrequest) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_q + LEN_W'(1);
                    if (issued_q + LEN_W'(1) == len_q) state_d = StDone;
                end
            end
            StRdCmd: begin
                if (!sdram_waitrequest) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_q + LEN_W'(1);
                    if (issued_q + LEN_W'(1) == len_q) state_d = rd_last ? StDone : StRdDrain;
                end
            end
            StRdDrain: begin
                if (rd_last) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            be_q       <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            be_q       <= be_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            rd_valid_q <= rd_beat;
            error_q    <= error_d;
            if (rd_beat) rd_data_q <= sdram_readdata;
        end
    end

    always_comb begin
        busy               = (state_q != StIdle);
        done               = (state_q == StDone);
        error              = error_q;
        rd_valid           = rd_valid_q;
        rd_data            = rd_data_q;
        wr_ready           = (state_q == StWrCmd) && !sdram_waitrequest;
        sdram_address      = addr_q;
        sdram_chipselect   = (state_q == StWrCmd) || (state_q == StRdCmd);
        sdram_write_n      = !((state_q == StWrCmd) && wr_valid);
        sdram_read_n       = !(state_q == StRdCmd);
        sdram_writedata    = (state_q == StWrCmd) ? wr_data : '0;
        sdram_byteenable_n = (state_q == StWrCmd) ? ~be_q : '0;
    end

endmodule

// File: tb/tb_sdram_burst_interface.sv
// Scoreboard bench for sdram_burst_interface with a fixed-latency SDRAM controller model.
module tb_sdram_burst_interface;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_write = 1'b0, start_read = 1'b0;
    logic [AW-1:0] address = '0;
    logic [LW-1:0] length = '0;
    logic [BW-1:0] byteenable = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, busy, done, error;
    logic [AW-1:0] sdram_address;
    logic [BW-1:0] sdram_byteenable_n;
    logic          sdram_chipselect, sdram_read_n, sdram_write_n;
    logic [DW-1:0] sdram_writedata;
    logic [DW-1:0] sdram_readdata = '0;
    logic          sdram_readdatavalid = 1'b0;
    logic          sdram_waitrequest = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 3;
    int done_count = 0;
    int last_done = -1;

    logic [AW-1:0] exp_wr_addr[$];
    logic [DW-1:0] exp_wr_data[$];
    logic [BW-1:0] exp_wr_ben[$];
    logic [AW-1:0] exp_rd_addr[$];
    logic [DW-1:0] exp_rd_data[$];
    int            pend_due[$];
    logic [DW-1:0] pend_data[$];
    int            rv_cyc[$];

    sdram_burst_interface dut (
        .clk                (clk),
        .reset              (reset),
        .start_write        (start_write),
        .start_read         (start_read),
        .address            (address),
        .length             (length),
        .byteenable         (byteenable),
        .wr_data            (wr_data),
        .wr_valid           (wr_valid),
        .wr_ready           (wr_ready),
        .rd_data            (rd_data),
        .rd_valid           (rd_valid),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .sdram_address      (sdram_address),
        .sdram_byteenable_n (sdram_byteenable_n),
        .sdram_chipselect   (sdram_chipselect),
        .sdram_writedata    (sdram_writedata),
        .sdram_read_n       (sdram_read_n),
        .sdram_write_n      (sdram_write_n),
        .sdram_readdata     (sdram_readdata),
        .sdram_readdatavalid(sdram_readdatavalid),
        .sdram_waitrequest  (sdram_waitrequest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    // Controller model: returns each accepted read lat cycles after acceptance.
    always @(posedge clk) begin
        #1;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            sdram_readdatavalid = 1'b1;
            sdram_readdata = pend_data.pop_front();
            void'(pend_due.pop_front());
        end else begin
            sdram_readdatavalid = 1'b0;
        end
    end

    // Bus monitor: pops the scoreboard on every accepted command and returned word.
    always @(negedge clk) begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] b;
        if (done) begin
            done_count++;
            last_done = cyc;
        end
        if (!sdram_write_n && !sdram_waitrequest) begin
            checks++;
            if (exp_wr_addr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", sdram_address, sdram_writedata);
            end else begin
                a = exp_wr_addr.pop_front();
                d = exp_wr_data.pop_front();
                b = exp_wr_ben.pop_front();
                if ({sdram_address, sdram_writedata, sdram_byteenable_n} !== {a, d, b}) begin
                    errors++;
                    $display("FAIL write_beat got addr=%h data=%h be_n=%b want addr=%h data=%h be_n=%b",
                             sdram_address, sdram_writedata, sdram_byteenable_n, a, d, b);
                end
            end
        end
        if (!sdram_read_n && !sdram_waitrequest) begin
            checks++;
            pend_due.push_back(cyc + lat);
            pend_data.push_back(model_data(sdram_address));
            if (exp_rd_addr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read addr=%h", sdram_address);
            end else begin
                a = exp_rd_addr.pop_front();
                if ({sdram_address, sdram_byteenable_n} !== {a, 2'b00}) begin
                    errors++;
                    $display("FAIL read_cmd got addr=%h be_n=%b want addr=%h be_n=00",
                             sdram_address, sdram_byteenable_n, a);
                end
            end
        end
        if (rd_valid) begin
            checks++;
            rv_cyc.push_back(cyc);
            if (exp_rd_data.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd_valid data=%h", rd_data);
            end else begin
                d = exp_rd_data.pop_front();
                if (rd_data !== d) begin
                    errors++;
                    $display("FAIL rd_data got %h want %h", rd_data, d);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, error, rd_valid, wr_ready, sdram_chipselect} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {busy, done, error, rd_valid, wr_ready, sdram_chipselect});
        end
        checks++;
        if ({sdram_read_n, sdram_write_n} !== 2'b11) begin
            errors++;
            $display("FAIL reset_rw_n got %b want 11", {sdram_read_n, sdram_write_n});
        end
        checks++;
        if ({sdram_address, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_regs got addr=%h rd_data=%h want 0", sdram_address, rd_data);
        end
    endtask

    task automatic test_write(input logic [AW-1:0] base, input int len, input logic [BW-1:0] be,
                              input bit stalls, input bit both);
        logic [DW-1:0] wd[$];
        int t0, idx, guard, wait_left, gap_left, dc0;
        bit wait_set, gap_set;
        for (int i = 0; i < len; i++) begin
            wd.push_back(DW'($urandom));
            exp_wr_addr.push_back(base + AW'(i));
            exp_wr_data.push_back(wd[i]);
            exp_wr_ben.push_back(~be);
        end
        dc0 = done_count;
        @(posedge clk);
        #1;
        start_write = 1'b1;
        start_read = both;
        address = base;
        length = LW'(len);
        byteenable = be;
        t0 = cyc;
        idx = 0; guard = 0; wait_left = 0; gap_left = 0; wait_set = 0; gap_set = 0;
        while (idx < len && guard < 60) begin
            @(posedge clk);
            #1;
            start_write = 1'b0;
            start_read = 1'b0;
            if (stalls && idx == 2 && !wait_set) begin wait_left = 2; wait_set = 1; end
            if (stalls && idx == 3 && !gap_set) begin gap_left = 1; gap_set = 1; end
            sdram_waitrequest = (wait_left > 0);
            wr_valid = (gap_left == 0);
            if (wait_left > 0) wait_left--;
            else if (gap_left > 0) gap_left--;
            wr_data = wd[idx];
            @(negedge clk);
            if (guard == 0) begin
                checks++;
                if ({busy, sdram_chipselect} !== 2'b11) begin
                    errors++;
                    $display("FAIL write_first_cycle busy/cs got %b want 11",
                             {busy, sdram_chipselect});
                end
            end
            if (sdram_waitrequest) begin
                checks++;
                if ({sdram_address, sdram_writedata, sdram_write_n, wr_ready} !==
                    {base + AW'(idx), wd[idx], 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL stall_hold got addr=%h data=%h want addr=%h data=%h",
                             sdram_address, sdram_writedata, base + AW'(idx), wd[idx]);
                end
            end
            if (!wr_valid) begin
                checks++;
                if (sdram_write_n !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_write_n got %b want 1", sdram_write_n);
                end
            end
            if (wr_valid && wr_ready) idx++;
            guard++;
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        sdram_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_count !== dc0 + 1 || exp_wr_addr.size() != 0) begin
            errors++;
            $display("FAIL write_done_count got %0d (left %0d) want %0d (left 0)",
                     done_count - dc0, exp_wr_addr.size(), 1);
        end
        if (!stalls) begin
            checks++;
            if (last_done !== t0 + len + 1) begin
                errors++;
                $display("FAIL write_done_time got %0d want %0d", last_done - t0, len + 1);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL write_busy_end got %b want 0", busy);
        end
    endtask

    task automatic test_read(input logic [AW-1:0] base, input int len, input int k);
        int t0, n0, dc0, guard;
        lat = k;
        for (int i = 0; i < len; i++) begin
            exp_rd_addr.push_back(base + AW'(i));
            exp_rd_data.push_back(model_data(base + AW'(i)));
        end
        n0 = rv_cyc.size();
        dc0 = done_count;
        @(posedge clk);
        #1;
        start_read = 1'b1;
        address = base;
        length = LW'(len);
        t0 = cyc;
        @(posedge clk);
        #1 start_read = 1'b0;
        guard = 0;
        while (rv_cyc.size() < n0 + len && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rv_cyc.size() != n0 + len) begin
            errors++;
            $display("FAIL read_beats got %0d want %0d", rv_cyc.size() - n0, len);
        end else begin
            for (int i = 0; i < len; i++) begin
                checks++;
                if (rv_cyc[n0 + i] != t0 + 2 + i + k) begin
                    errors++;
                    $display("FAIL read_beat_time beat %0d got %0d want %0d",
                             i, rv_cyc[n0 + i] - t0, 2 + i + k);
                end
            end
            checks++;
            if (done_count != dc0 + 1 || last_done < rv_cyc[n0 + len - 1] ||
                last_done > rv_cyc[n0 + len - 1] + 1) begin
                errors++;
                $display("FAIL read_done got count %0d at %0d want 1 at last rd_valid %0d",
                         done_count - dc0, last_done, rv_cyc[n0 + len - 1]);
            end
        end
    endtask

    task automatic test_error(input logic [LW-1:0] len, input bit is_write);
        @(posedge clk);
        #1;
        start_write = is_write;
        start_read = !is_write;
        length = len;
        @(posedge clk);
        #1;
        start_write = 1'b0;
        start_read = 1'b0;
        @(negedge clk);
        checks++;
        if ({error, busy} !== 2'b10) begin
            errors++;
            $display("FAIL error_pulse len=%0d got error/busy %b want 10", len, {error, busy});
        end
        @(negedge clk);
        checks++;
        if ({error, busy} !== 2'b00) begin
            errors++;
            $display("FAIL error_clear len=%0d got error/busy %b want 00", len, {error, busy});
        end
    endtask

    task automatic test_reset_drain();
        int t0, n0, dc0;
        lat = 5;
        for (int i = 0; i < 4; i++) begin
            exp_rd_addr.push_back(AW'(32'h100 + i));
            exp_rd_data.push_back(model_data(AW'(32'h100 + i)));
        end
        n0 = rv_cyc.size();
        dc0 = done_count;
        @(posedge clk);
        #1;
        start_read = 1'b1;
        address = AW'(32'h100);
        length = 4'd4;
        t0 = cyc;
        @(posedge clk);
        #1 start_read = 1'b0;
        // Cycle t0+7: one word delivered, three still in flight.
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_rd_data.delete();
        @(negedge clk);
        checks++;
        if ({busy, done, rd_valid, sdram_chipselect, sdram_read_n, sdram_write_n} !== 6'b000011 ||
            sdram_address !== '0) begin
            errors++;
            $display("FAIL abort_state got %b addr=%h want 000011 addr=0",
                     {busy, done, rd_valid, sdram_chipselect, sdram_read_n, sdram_write_n},
                     sdram_address);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (rv_cyc.size() != n0 + 1 || done_count != dc0) begin
            errors++;
            $display("FAIL abort_drop got rd_valid %0d done %0d want 1 and 0",
                     rv_cyc.size() - n0, done_count - dc0);
        end
    endtask

    initial begin
        test_reset();
        test_write(AW'(32'h10), 4, 2'b11, 1'b0, 1'b0);
        test_read(AW'(32'h1FFFFFE), 8, 3);
        test_write(AW'(32'h20), 5, 2'b01, 1'b1, 1'b0);
        test_write(AW'(32'h40), 1, 2'b10, 1'b0, 1'b1);
        test_error(4'd0, 1'b1);
        test_error(4'd9, 1'b0);
        test_read(AW'(32'h300), 3, 1);
        test_reset_drain();
        checks++;
        if (exp_wr_addr.size() + exp_rd_addr.size() + exp_rd_data.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0",
                     exp_wr_addr.size() + exp_rd_addr.size() + exp_rd_data.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_burst_interface.md
# sdram_burst_interface

Parametrised burst front end for the SDRAM controller. It turns a single user command (start pulse, base address, length) into a sequence of Avalon-style word transfers, with consecutive addresses, toward the SDRAM controller. Reads are pipelined: a new command is issued every accepted cycle without waiting for earlier data to return. Write data arrives and read data leaves as valid/ready streams. The block sits between user logic and the SDRAM controller and replaces single-word access for bulk transfers.

## Interface
Parameters:
- ADDR_W, 25, word address width
- DATA_W, 16, data width; must be a multiple of 8
- BE_W, DATA_W/8, byte-enable width (derived)
- MAX_BURST, 8, maximum words per command; must be ≥1
- LEN_W, $clog2(MAX_BURST+1), width of the length field

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- start_write  in  1  one-cycle pulse; starts a write burst
- start_read  in  1  one-cycle pulse; starts a read burst
- address  in  ADDR_W  base word address, sampled with start
- length  in  LEN_W  word count, sampled with start; legal range 1..MAX_BURST
- byteenable  in  BE_W  active-high byte mask, sampled with start, applied to every write word
- wr_data  in  DATA_W  write stream data
- wr_valid  in  1  write stream valid
- wr_ready  out  1  write word consumed this cycle when high together with wr_valid
- rd_data  out  DATA_W  read stream data
- rd_valid  out  1  one-cycle pulse per returned word; there is no back-pressure
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse when a start is rejected
- sdram_address  out  ADDR_W  word address
- sdram_byteenable_n  out  BE_W  active-low byte enables
- sdram_chipselect  out  1  high during command states
- sdram_writedata  out  DATA_W  write data
- sdram_read_n  out  1  active-low read request
- sdram_write_n  out  1  active-low write request
- sdram_readdata  in  DATA_W  returned data
- sdram_readdatavalid  in  1  returned data valid
- sdram_waitrequest  in  1  controller stall

## Operation
- States:
  - IDLE: waiting for a start.
  - WR_CMD: issuing write words.
  - RD_CMD: issuing read commands.
  - RD_DRAIN: all read commands issued; waiting for the remaining data.
  - DONE: one cycle, then back to IDLE.
- Start handling:
  - In IDLE, a start with 1 ≤ length ≤ MAX_BURST registers address, length and byteenable, clears both counters, and moves to WR_CMD (write) or RD_CMD (read).
  - If start_write and start_read are high together, the write wins.
  - length == 0 or length > MAX_BURST: stay in IDLE and pulse error on the next cycle.
  - Start pulses are ignored while busy.
- WR_CMD:
  - sdram_write_n = !wr_valid; sdram_writedata = wr_data (combinational pass-through); wr_ready = !sdram_waitrequest.
  - A beat is accepted when wr_valid && !sdram_waitrequest. Each accepted beat increments the address register and the issued counter.
  - When issued == length on an accepted beat, go to DONE.
- RD_CMD:
  - sdram_read_n = 0. Each cycle with !sdram_waitrequest increments the address and the issued counter.
  - When the last command is accepted, go to RD_DRAIN. If the last data word returns in that same cycle, go directly to DONE.
- Read data returns in RD_CMD and RD_DRAIN:
  - Each sdram_readdatavalid increments the returned counter and pulses rd_valid with rd_data = sdram_readdata, registered (one cycle later).
  - Go to DONE when returned reaches length.
- sdram_readdatavalid arriving in IDLE, WR_CMD or DONE is ignored: no rd_valid, no count.
- sdram_address = the address register. It wraps modulo 2^ADDR_W.
- sdram_byteenable_n = ~byteenable for writes and all zeros for reads. sdram_chipselect = 1 only in WR_CMD and RD_CMD.
- Reset values: state IDLE, counters 0, busy/done/error/rd_valid/wr_ready/sdram_chipselect = 0, sdram_read_n = sdram_write_n = 1, registered data/address = 0.
- Reset mid-burst aborts immediately: the next cycle is IDLE with all outputs at reset values. No done pulse is produced, and any read data still in flight is dropped.

## Timing
- Start at cycle T → busy = 1 and the first command presented at T+1.
- done is high for exactly one cycle: the cycle in DONE. busy drops on the following cycle.
- Back-to-back commands: a new start is accepted at the earliest in the cycle after DONE.
- Write burst with no waitrequest and wr_valid always high: L command cycles, done at T+L+1.
- Read burst with controller latency K (readdatavalid K cycles after command acceptance): rd_valid for beat i at T+1+i+K+1. done in the cycle after the last rd_valid is registered.
- Address, write data and control are held stable while sdram_waitrequest = 1.

## Test plan
- Write with length=4, address=0x10, byteenable=2'b11, wr_valid held high, no stalls → writes to 0x10..0x13 with data in stream order, byteenable_n=00, done at T+5.
- Read with length=8, address=0x1FFFFFE, controller latency 3 → addresses wrap as 0x1FFFFFE, 0x1FFFFFF, 0x0..0x5; 8 rd_valid pulses in order; done exactly once.
- Write with waitrequest asserted for 2 cycles on beat 2 and wr_valid low for 1 cycle on beat 3 → address and data hold during the stall; no beat is lost or duplicated.
- start_write and start_read in the same cycle with length=1 → write executes and the read is ignored; start with length=0 or length=9 → error pulse, busy stays 0.
- Reset asserted during RD_DRAIN with 3 beats outstanding → next cycle is IDLE; the late readdatavalid pulses produce no rd_valid and no done.
